// File: rtl/plic_claim_complete.sv
// PLIC pending/in-service tracking, priority arbitration and the claim/complete register.
// Define PLIC_EDGE_TRIG_EN for rising-edge request sources with one-deep deferral while in service.
module plic_claim_complete #(
  parameter int unsigned N_interrupts = 32,
  parameter int unsigned ID_W         = 10
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [N_interrupts-1:0] interrupt_requests,
  input  logic [N_interrupts-1:0] interrupt_masks,
  input  logic [31:0]             interrupt_priority_regs [N_interrupts],
  input  logic [31:0]             claim_complete_addr,
  input  logic [31:0]             addr,
  input  logic                    ren,
  input  logic                    wen,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    addr_valid,
  output logic                    interrupt_service_request,
  output logic [N_interrupts-1:0] interrupt_pending
);

  localparam int unsigned N = N_interrupts;

  logic [N-1:0]    pending_q, pending_d;
  logic [N-1:0]    in_service_q, in_service_d;
  logic [N-1:0]    claim_vec, comp_vec, claim_hit, comp_hit, pend_set;
  logic [ID_W-1:0] best_id_q, best_id;
  logic [31:0]     best_prio;
  logic            found;
  logic            irq_q;
  logic            claim, complete;

`ifdef PLIC_EDGE_TRIG_EN
  logic [N-1:0] req_q, deferred_q, deferred_d, rise, defer_hit;
`endif

  assign addr_valid = (addr == claim_complete_addr);
  assign claim      = addr_valid & ren & ~wen & (best_id_q != '0);
  assign complete   = addr_valid & wen;
  assign rdata      = (addr_valid & ren) ? 32'(best_id_q) : 32'd0;

  assign interrupt_service_request = irq_q;
  assign interrupt_pending         = pending_q;

  // Highest unsigned priority among unmasked pending sources; strict > keeps the lowest ID on ties.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pending_q[i] && !interrupt_masks[i] &&
          (!found || interrupt_priority_regs[i] > best_prio)) begin
        found     = 1'b1;
        best_prio = interrupt_priority_regs[i];
        best_id   = ID_W'(i + 1);
      end
    end
  end

  // One-hot decode of the claimed ID and the written complete ID.
  always_comb begin
    claim_vec = '0;
    comp_vec  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      claim_vec[i] = claim && (best_id_q == ID_W'(i + 1));
      comp_vec[i]  = complete && (wdata == 32'(i + 1));
    end
  end

  always_comb begin
    claim_hit = claim_vec & pending_q;
    comp_hit  = comp_vec & in_service_q;
`ifdef PLIC_EDGE_TRIG_EN
    rise       = interrupt_requests & ~req_q;
    defer_hit  = deferred_q | (rise & in_service_q);
    deferred_d = defer_hit & ~comp_hit;
    pend_set   = (rise & ~pending_q & ~in_service_q) | (defer_hit & comp_hit);
`else
    pend_set   = interrupt_requests & ~pending_q & ~in_service_q;
`endif
    pending_d    = (pending_q | pend_set) & ~claim_hit;
    in_service_d = (in_service_q | claim_hit) & ~comp_hit;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pending_q    <= '0;
      in_service_q <= '0;
      best_id_q    <= '0;
      irq_q        <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      best_id_q    <= best_id;
      irq_q        <= (best_id != '0);
    end
  end

`ifdef PLIC_EDGE_TRIG_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_q      <= '0;
      deferred_q <= '0;
    end else begin
      req_q      <= interrupt_requests;
      deferred_q <= deferred_d;
    end
  end
`endif

endmodule
